pc_sequencer: RTL

Parametrised program-counter sequencer feeding the instruction-fetch stage of the CPU core.
- Issues fetch addresses over a valid/ready handshake only when every execution unit reports empty.
- Blocks fetch after a decoded branch until that branch resolves.
- Accepts a commit-time PC redirect that overrides everything.
- Keeps stall and fetch counters for performance debug.

---
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Fetch request handshake between the PC sequencer (master) and
//               the instruction memory (slave).
//                 fetchValid : request valid, driven by the sequencer
//                 fetchReady : request accepted, driven by instruction memory
//                 fetchPc    : request address, driven by the sequencer
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  fetchValid;
    logic                  fetchReady;
    logic [ADDR_WIDTH-1:0] fetchPc;

    modport master (
        output fetchValid,
        output fetchPc,
        input  fetchReady
    );

    modport slave (
        input  fetchValid,
        input  fetchPc,
        output fetchReady
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer for the instruction-fetch stage.
//               Issues fetch requests only while all execution units are
//               empty, blocks fetch in the shadow of a decoded branch until it
//               resolves, and honours a commit-time redirect above all else.
//               Keeps stall / fetch performance counters.
// Ports       : clock, reset      - clock, async active-high reset
//               unitEmpty         - per-unit empty flags gating fetch
//               opValid/operatorType - decoded opcode (branch detection)
//               fetch (master)    - fetchValid / fetchReady / fetchPc
//               decodePulse       - one-cycle pulse after each accepted fetch
//               branchResolve/branchTaken/branchTarget - branch outcome
//               pcChange/changeData - commit redirect
//               branchPending     - high while waiting for a branch
//               stallCount        - saturating count of non-fire cycles
//               fetchCount        - wrapping count of accepted fetches
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 1,
    parameter int                    NUM_UNITS  = 5,
    parameter logic [6:0]            BRANCH_OP  = 7'b1100011,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_UNITS-1:0]  unitEmpty,
    input  logic                  opValid,
    input  logic [6:0]            operatorType,
    pc_sequencer_if.master        fetch,
    output logic                  decodePulse,
    input  logic                  branchResolve,
    input  logic                  branchTaken,
    input  logic [ADDR_WIDTH-1:0] branchTarget,
    input  logic                  pcChange,
    input  logic [ADDR_WIDTH-1:0] changeData,
    output logic                  branchPending,
    output logic [CNT_WIDTH-1:0]  stallCount,
    output logic [CNT_WIDTH-1:0]  fetchCount
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_BR_WAIT = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_pc_step  = ADDR_WIDTH'(PC_STEP);
    localparam logic [CNT_WIDTH-1:0]  c_cnt_one  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  c_cnt_max  = '1;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic [CNT_WIDTH-1:0]  r_stall;
    logic [CNT_WIDTH-1:0]  r_fcnt;
    logic                  r_decode;

    logic w_all_empty;
    logic w_is_branch;
    logic w_fetch_valid;
    logic w_fire;

    assign w_all_empty   = &unitEmpty;
    assign w_is_branch   = opValid && (operatorType == BRANCH_OP);
    // A branch or redirect seen this cycle suppresses the request at once so
    // that no instruction from the wrong path is fetched.
    assign w_fetch_valid = (r_state == ST_RUN) && w_all_empty && !w_is_branch && !pcChange;
    assign w_fire        = w_fetch_valid && fetch.fetchReady;

    assign fetch.fetchValid = w_fetch_valid;
    assign fetch.fetchPc    = r_pc;
    assign decodePulse      = r_decode;
    assign branchPending    = (r_state == ST_BR_WAIT);
    assign stallCount       = r_stall;
    assign fetchCount       = r_fcnt;

    // Next-state and next-pc; the redirect wins over everything else.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        if (pcChange) begin
            w_next_state = ST_RUN;
            w_next_pc    = changeData;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_RUN;
                end
                ST_RUN: begin
                    if (w_is_branch) begin
                        w_next_state = ST_BR_WAIT;
                    end else if (w_fire) begin
                        w_next_pc = r_pc + c_pc_step;
                    end
                end
                ST_BR_WAIT: begin
                    if (branchResolve) begin
                        w_next_state = ST_RUN;
                        if (branchTaken) begin
                            w_next_pc = branchTarget;
                        end
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall  <= '0;
            r_fcnt   <= '0;
            r_decode <= 1'b0;
        end else begin
            r_decode <= w_fire;
            if (w_fire) begin
                r_fcnt <= r_fcnt + c_cnt_one;
            end
            // Saturate rather than wrap so a long stall stays visible.
            if ((r_state != ST_IDLE) && !w_fire && (r_stall != c_cnt_max)) begin
                r_stall <= r_stall + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire
